// File: rtl/count_display_pkg.sv
// Shared types and constants for count_display: converter FSM states,
// digit-index type, anode one-hot patterns and active-low segment encodings.
package count_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t DIG_ONES     = 2'd0;
  localparam digit_idx_t DIG_TENS     = 2'd1;
  localparam digit_idx_t DIG_HUNDREDS = 2'd2;

  localparam logic [2:0] AN_OFF      = 3'b111;
  localparam logic [2:0] AN_ONES     = 3'b110;
  localparam logic [2:0] AN_TENS     = 3'b101;
  localparam logic [2:0] AN_HUNDREDS = 3'b011;

  // Segment order {g,f,e,d,c,b,a}, a low bit lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DIGITS [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    if (nib < 4'd10) return SEG_DIGITS[nib];
    return SEG_BLANK;
  endfunction

  function automatic logic [2:0] an_for(input digit_idx_t idx);
    case (idx)
      DIG_TENS:     return AN_TENS;
      DIG_HUNDREDS: return AN_HUNDREDS;
      default:      return AN_ONES;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD digits in
// 10 cycles, restarting whenever the input differs from the last converted value.
module bin2bcd_seq
  import count_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic [11:0] bcd
);

  conv_state_t state, state_next;
  logic [19:0] shreg, shreg_adj;
  logic [2:0]  shift_cnt;
  logic [7:0]  latched, last_value;
  logic        last_valid;
  logic        start;

  assign start = (state == IDLE) && (!last_valid || (bin != last_value));

  // Add-3 correction on every BCD nibble that would reach 10 or more after doubling.
  always_comb begin
    shreg_adj = shreg;
    for (int i = 0; i < 3; i++) begin
      if (shreg[8+4*i +: 4] >= 4'd5)
        shreg_adj[8+4*i +: 4] = shreg[8+4*i +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the default assignment before the case keeps this block purely
  // combinational; any path leaving state_next unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (shift_cnt == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the shift register and latched input are reset along with the
  // control state, so an aborted conversion can never leak partial digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      shift_cnt  <= '0;
      latched    <= '0;
      last_value <= '0;
      last_valid <= 1'b0;
      busy       <= 1'b0;
      bcd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg     <= {12'd0, bin};
            latched   <= bin;
            shift_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          shreg     <= shreg_adj << 1;
          shift_cnt <= shift_cnt + 3'd1;
        end
        DONE: begin
          bcd        <= shreg[19:8];
          last_value <= latched;
          last_valid <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/count_display.sv
// Binary count to 3-digit multiplexed common-anode 7-segment display.
// Define COUNT_DISPLAY_LZ_BLANK_EN to blank leading zeros on hundreds/tens.
module count_display
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  digit_idx_t       digit_idx;
  logic [3:0]       nib;
  logic             blank;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (reset),
    .bin   (in),
    .busy  (busy),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      digit_idx <= DIG_ONES;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      digit_idx <= (digit_idx == DIG_HUNDREDS) ? DIG_ONES : digit_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    nib   = bcd[3:0];
    blank = 1'b0;
    case (digit_idx)
      DIG_TENS: begin
        nib = bcd[7:4];
`ifdef COUNT_DISPLAY_LZ_BLANK_EN
        blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
`endif
      end
      DIG_HUNDREDS: begin
        nib = bcd[11:8];
`ifdef COUNT_DISPLAY_LZ_BLANK_EN
        blank = (bcd[11:8] == 4'd0);
`endif
      end
      default: ;
    endcase
  end

  // Anodes and segments are registered together so they switch on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_for(digit_idx);
      seg <= blank ? SEG_BLANK : seg_decode(nib);
    end
  end

endmodule

// File: tb/tb_count_display.sv
// Self-checking bench for count_display: directed scenarios plus random input
// changes, compared every cycle against a latency/arithmetic reference model.
module tb_count_display;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        busy;
  logic [11:0] bcd;
  logic [2:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = idle, 1..9 = cycles since a conversion started.
  int         m_phase, m_lat, m_last, m_val, k;
  bit         m_lv;
  logic [2:0] e_an;
  logic [6:0] e_seg;

  count_display #(.REFRESH_DIV(RD), .DIV_W(3)) dut (
    .clk   (clk),
    .reset (rst_n),
    .in    (din),
    .busy  (busy),
    .bcd   (bcd),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_lat = 0; m_last = 0; m_val = 0; m_lv = 1'b0; k = 0;
    e_an = 3'b111; e_seg = 7'b1111111;
  endtask

  // Predicts the effect of the coming rising edge, using the current input.
  task automatic model_edge();
    int  idx, dv;
    bit  blank;
    idx   = (k / RD) % 3;
    blank = 1'b0;
    case (idx)
      0:       dv = m_val % 10;
      1:       dv = (m_val / 10) % 10;
      default: dv = m_val / 100;
    endcase
`ifdef COUNT_DISPLAY_LZ_BLANK_EN
    if (idx == 2 && m_val < 100) blank = 1'b1;
    if (idx == 1 && m_val < 10)  blank = 1'b1;
`endif
    e_an  = (idx == 0) ? 3'b110 : (idx == 1) ? 3'b101 : 3'b011;
    e_seg = blank ? 7'b1111111 : digit_seg(dv);
    if (m_phase == 0) begin
      if (!m_lv || int'(din) != m_last) begin
        m_lat   = int'(din);
        m_phase = 1;
      end
    end else if (m_phase < 9) begin
      m_phase++;
    end else begin
      m_val   = m_lat;
      m_last  = m_lat;
      m_lv    = 1'b1;
      m_phase = 0;
    end
    k++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("bcd",  32'(bcd),  32'(to_bcd(m_val)));
    check("an",   32'(an),   32'(e_an));
    check("seg",  32'(seg),  32'(e_seg));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_bcd"},  32'(bcd),  32'h000);
    check({tag, "_an"},   32'(an),   32'b111);
    check({tag, "_seg"},  32'(seg),  32'b1111111);
  endtask

  initial begin
    din   = 8'd0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Forced conversion of 0 after reset, then the 255 maximum.
    din = 8'd0;   steps(12);
    din = 8'd255; steps(12);

    // Input change during a conversion is picked up on return to IDLE.
    din = 8'd37;  steps(2);
    din = 8'd200; steps(20);

    // Full scan cycles on a three-digit value, then a single-digit value.
    din = 8'd125; steps(12 + 6 * RD);
    din = 8'd7;   steps(12 + 6 * RD);
    din = 8'd40;  steps(12 + 3 * RD);

    // Reset asserted in the 4th SHIFT cycle of a conversion.
    din = 8'd99;
    for (int i = 0; i < 20 && m_phase != 4; i++) step();
    check("reached_shift4", 32'(m_phase), 32'd4);
    rst_n = 1'b0;
    #1 check_reset_values("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    steps(14);

    // Random input changes, sometimes mid-conversion.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) == 0) din = 8'($urandom_range(255, 0));
      step();
    end
    steps(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
